uart_rx_axis: RTL
=================

UART_RX_AXIS -- requirements
Module: uart_rx_axis

Interface
REQ-001 SHALL have parameter clk_rate, default 100000000, meaning the clock frequency in Hz.
REQ-002 SHALL have parameter Baud, default 115200, meaning the line bit rate; Baud_div = clk_rate/Baud (integer division), Half_div = Baud_div/2.
REQ-003 SHALL have parameter Word_len, default 8, meaning data bits per frame.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port Uart_rx, input, 1 bit: serial line, idle high.
REQ-007 SHALL have port rx_data, output, Word_len bits: received word.
REQ-008 SHALL have port rx_data_valid, output, 1 bit: rx_data holds an unconsumed word.
REQ-009 SHALL have port rx_data_ready, input, 1 bit: consumer accepts the word.
REQ-010 SHALL have port rx_frame_err, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
REQ-011 SHALL have port rx_overrun, output, 1 bit: one-cycle pulse when a good word is dropped.

Function
REQ-012 SHALL have the states IDLE, START, DATA and STOP, using a baud counter of width $clog2(Baud_div)+1 and a bit counter of width $clog2(Word_len+1).
REQ-013 IDLE: counters held at 0; a sampled line value (rx_s) of 0 SHALL move to START.
REQ-014 START: SHALL count to Half_div-1 and then check rx_s; 0 -> DATA with the counter cleared; 1 (false start/glitch) -> IDLE, no output.
REQ-015 DATA: SHALL sample rx_s at every baud count of Baud_div-1 and shift it in LSB-first; after the Word_len-th sample -> STOP.
REQ-016 STOP: SHALL sample rx_s at a baud count of Baud_div-1, then go to IDLE on the same edge (mid-stop-bit resync).
REQ-017 Stop sample = 1 SHALL commit the shift register to the output buffer; stop sample = 0 SHALL discard the word and pulse rx_frame_err for 1 cycle.
REQ-018 Output handshake: the buffer is single-entry; rx_data_valid SHALL rise the cycle after commit and hold with rx_data stable until a cycle where rx_data_valid && rx_data_ready.
REQ-019 A commit while the buffer is full and not being consumed that cycle SHALL drop the new word, keep the old word and pulse rx_overrun for 1 cycle.
REQ-020 A commit in the same cycle as a consume SHALL load the new word with rx_data_valid staying 1 (no bubble, no overrun).
REQ-021 rx_data_ready SHALL be ignored while rx_data_valid=0; reception SHALL never stall on rx_data_ready.
REQ-022 Frame length from the detected falling edge to commit SHALL be Half_div + Word_len*Baud_div + Baud_div cycles (plus synchronizer latency, see REQ-026).

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE, clear all counters, the shift register, rx_data and the synchronizer flops (synchronizer flops reset to 1), and drive rx_data_valid=0, rx_frame_err=0, rx_overrun=0.
REQ-024 Reset during any state SHALL abandon the partial frame; after release, reception SHALL restart only on a new falling edge.

Configuration
REQ-025 Macro UART_RX_SYNC_EN SHALL select the input path.
REQ-026 With UART_RX_SYNC_EN defined: rx_s SHALL be Uart_rx passed through two flops (2-cycle latency).
REQ-027 Without UART_RX_SYNC_EN: rx_s SHALL be Uart_rx registered once (1-cycle latency); all other behaviour is identical.

Verification (clk_rate=1000000, Baud=100000 -> Baud_div=10, Half_div=5, Word_len=8)
REQ-028 Send 0xA5 (8N1) with rx_data_ready=1 -> rx_data=0xA5 with rx_data_valid high for exactly 1 cycle, no error pulses.
REQ-029 A 3-cycle low glitch on an idle line -> START aborts; no valid, no rx_frame_err.
REQ-030 Send 0x3C with the stop bit forced low -> one rx_frame_err pulse, rx_data_valid stays 0.
REQ-031 rx_data_ready=0; send 0x11 then 0x22 -> rx_data holds 0x11, one rx_overrun pulse; raising ready consumes 0x11 and no 0x22 appears.
REQ-032 Back-to-back frames 0x01 and 0x02, with ready asserted exactly on the commit cycle of 0x02 -> both received in order, no overrun.
REQ-033 Assert rst_n=0 mid-DATA of 0xFF, release, then send 0x5A -> only 0x5A is output, with correct timing under both macro settings.

Source files
------------

// File: rtl/uart_rx_axis.sv
// UART receiver (8N1-style, LSB first) with a single-entry valid/ready output buffer.
// Define UART_RX_SYNC_EN for a two-flop input synchronizer; otherwise the line is registered once.
module uart_rx_axis #(
  parameter int clk_rate = 100000000,
  parameter int Baud     = 115200,
  parameter int Word_len = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Uart_rx,
  output logic [Word_len-1:0] rx_data,
  output logic                rx_data_valid,
  input  logic                rx_data_ready,
  output logic                rx_frame_err,
  output logic                rx_overrun
);

  localparam int Baud_div = clk_rate / Baud;
  localparam int Half_div = Baud_div / 2;
  localparam int CNT_W    = $clog2(Baud_div) + 1;
  localparam int BIT_W    = $clog2(Word_len + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(Half_div - 1);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(Baud_div - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(Word_len - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [Word_len-1:0] shift_q, shift_d;
  logic [Word_len-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic                commit_ok, commit_bad, consume;
  logic                rx_s;

  // Synchronizer flops reset to 1 so a reset never looks like a start bit.
`ifdef UART_RX_SYNC_EN
  logic rx_meta_q, rx_s_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= Uart_rx;
      rx_s_q    <= rx_meta_q;
    end
  end
`else
  logic rx_s_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_s_q <= 1'b1;
    else        rx_s_q <= Uart_rx;
  end
`endif
  assign rx_s = rx_s_q;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    commit_ok  = 1'b0;
    commit_bad = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = '0;
          state_d    = rx_s ? IDLE : DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          shift_d    = {rx_s, shift_q[Word_len-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        // Leave at mid-stop-bit so the next start edge is never missed.
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          state_d    = IDLE;
          commit_ok  = rx_s;
          commit_bad = !rx_s;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    consume     = valid_q && rx_data_ready;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_err_d = commit_bad;
    if (consume) valid_d = 1'b0;
    if (commit_ok) begin
      // A consume on the same edge frees the slot, so the new word loads without a bubble.
      if (!valid_q || consume) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
  assign rx_frame_err  = frame_err_q;
  assign rx_overrun    = overrun_q;

endmodule
